// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - IF stage: fetch PC, IMEM word reads, 2-entry {pc,inst} buffer toward ID
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h4000_0000,
  parameter int          AWIDTH   = 14,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              imem_req,
  output logic [AWIDTH-1:0] imem_addr,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rdata,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [31:0]       id_inst,
  output logic [31:0]       id_pc
);

  typedef enum logic {BOOT, RUN} state_t;

  state_t      state;
  logic [31:0] pc_f;
  logic [31:0] req_pc;
  logic [1:0]  count;
  logic        inflight;
  logic        kill;
  logic [31:0] e0_pc, e0_inst;
  logic [31:0] e1_pc, e1_inst;

  logic        pop;
  logic        push;
  logic        issue;
  logic [2:0]  occ;
  logic [31:0] target;

  assign target    = redirect_pc & 32'hFFFF_FFFC;
  assign pop       = (count != 2'd0) & id_ready & ~redirect_valid;
  // pop never happens with count==0, so occ cannot underflow
  assign occ       = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign issue     = (state == RUN) & ~redirect_valid & (occ < 3'd2);
  assign push      = imem_rsp_valid & inflight & ~kill & ~redirect_valid;

  assign imem_req  = issue;
  assign imem_addr = pc_f[AWIDTH+1:2];
  assign id_valid  = (count != 2'd0) & ~redirect_valid;
  assign id_inst   = id_valid ? e0_inst : NOP;
  assign id_pc     = id_valid ? e0_pc : 32'h0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= BOOT;
      pc_f     <= RESET_PC;
      req_pc   <= RESET_PC;
      count    <= 2'd0;
      inflight <= 1'b0;
      kill     <= 1'b0;
      e0_pc    <= 32'h0;
      e0_inst  <= NOP;
      e1_pc    <= 32'h0;
      e1_inst  <= NOP;
    end else begin
      inflight <= issue;
      kill     <= 1'b0;
      if (state == BOOT) begin
        state <= RUN;
      end else if (redirect_valid) begin
        count <= 2'd0;
        pc_f  <= target;
        kill  <= inflight;
      end else begin
        if (issue) begin
          pc_f   <= pc_f + 32'd4;
          req_pc <= pc_f;
        end
        // e0 is the head; e1 only ever holds the entry behind it
        case ({push, pop})
          2'b10: begin
            if (count == 2'd0) begin
              e0_pc   <= req_pc;
              e0_inst <= imem_rdata;
            end else begin
              e1_pc   <= req_pc;
              e1_inst <= imem_rdata;
            end
            count <= count + 2'd1;
          end
          2'b01: begin
            e0_pc   <= e1_pc;
            e0_inst <= e1_inst;
            count   <= count - 2'd1;
          end
          2'b11: begin
            if (count == 2'd1) begin
              e0_pc   <= req_pc;
              e0_inst <= imem_rdata;
            end else begin
              e0_pc   <= e1_pc;
              e0_inst <= e1_inst;
              e1_pc   <= req_pc;
              e1_inst <= imem_rdata;
            end
          end
          default: ;
        endcase
      end
    end
  end

  a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && count == 2'd2));

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - scoreboard bench for inst_fetch with random ready/redirect stress
module tb_inst_fetch;
  localparam logic [31:0] RESET_PC = 32'h4000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        id_ready = 1'b0;
  logic        imem_req;
  logic [13:0] imem_addr;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc;

  int errors = 0;
  int checks = 0;
  int hs = 0;
  int hs_before;
  logic        cap_req = 1'b0;
  logic [13:0] cap_addr = 14'h0;
  logic [31:0] exp_q[$];
  logic [31:0] e;

  always #5 clk = ~clk;

  inst_fetch #(.RESET_PC(RESET_PC), .AWIDTH(14), .NOP(NOP)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rdata(imem_rdata),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_inst(id_inst), .id_pc(id_pc)
  );

  function automatic logic [31:0] word_of(input logic [13:0] a);
    return {a, 18'h0} ^ {18'h0, a} ^ 32'h9E37_79B9;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: the queue head is the next architectural PC ID must see
  always @(negedge clk) begin
    if (!rst) begin
      if (id_valid && id_ready) begin
        hs++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_empty: got pc %h expected none", id_pc);
        end else begin
          e = exp_q.pop_front();
          chk("id_pc", id_pc, e);
          chk("id_inst", id_inst, word_of(e[15:2]));
          exp_q.push_back(e + 32'd4);
        end
      end else if (!id_valid) begin
        chk("idle_inst", id_inst, NOP);
        chk("idle_pc", id_pc, 32'h0);
      end
    end
  end

  task automatic cyc(input logic rdy, input logic redir, input logic [31:0] tgt, input logic frsp);
    @(posedge clk);
    #1;
    imem_rsp_valid = cap_req | frsp;
    imem_rdata     = cap_req ? word_of(cap_addr) : 32'hDEAD_BEEF;
    id_ready       = rdy;
    redirect_valid = redir;
    redirect_pc    = tgt;
    if (redir) begin
      exp_q.delete();
      exp_q.push_back({tgt[31:2], 2'b00});
    end
    @(negedge clk);
    cap_req  = imem_req;
    cap_addr = imem_addr;
  endtask

  task automatic release_rst();
    @(posedge clk);
    #1;
    rst            = 1'b0;
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    id_ready       = 1'b1;
    exp_q.delete();
    exp_q.push_back(RESET_PC);
    @(negedge clk);
    cap_req  = imem_req;
    cap_addr = imem_addr;
  endtask

  task automatic boot_check(input string tag);
    release_rst();
    chk({tag, "_c0_req"}, 32'(imem_req), 32'd0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    chk({tag, "_c1_req"}, 32'(imem_req), 32'd1);
    chk({tag, "_c1_addr"}, 32'(imem_addr), 32'(RESET_PC[15:2]));
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    chk({tag, "_c2_valid"}, 32'(id_valid), 32'd0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    chk({tag, "_c3_valid"}, 32'(id_valid), 32'd1);
    chk({tag, "_c3_pc"}, id_pc, RESET_PC);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(id_valid), 32'd0);
    chk("rst_inst", id_inst, NOP);
    chk("rst_pc", id_pc, 32'h0);
    chk("rst_req", 32'(imem_req), 32'd0);

    boot_check("boot");
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 1'b0, 32'h0, 1'b0);
      chk("steady_valid", 32'(id_valid), 32'd1);
    end

    // backpressure: buffer fills, requests stop
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, 32'h0, 1'b0);
      chk("stall_valid", 32'(id_valid), 32'd1);
      chk("stall_req", 32'(imem_req), 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, 32'h0, 1'b0);
      chk("resume_valid", 32'(id_valid), 32'd1);
    end

    // redirect while a word is in flight
    cyc(1'b1, 1'b1, 32'h4000_0103, 1'b0);
    chk("redir_squash", 32'(id_valid), 32'd0);
    chk("redir_noreq", 32'(imem_req), 32'd0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    chk("redir_t1_req", 32'(imem_req), 32'd1);
    chk("redir_t1_addr", 32'(imem_addr), 32'h40);
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    chk("redir_t2_valid", 32'(id_valid), 32'd0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    chk("redir_t3_pc", id_pc, 32'h4000_0100);
    repeat (3) cyc(1'b1, 1'b0, 32'h0, 1'b0);

    // redirect with full buffer, ready high and a response strobe present
    repeat (3) cyc(1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 1'b1, 32'h4000_0200, 1'b1);
    chk("full_redir_squash", 32'(id_valid), 32'd0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    chk("full_redir_addr", 32'(imem_addr), 32'h80);
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    chk("full_redir_pc", id_pc, 32'h4000_0200);

    // back-to-back redirects, second target wraps past 2^32
    cyc(1'b1, 1'b1, 32'h1234_5678, 1'b0);
    cyc(1'b1, 1'b1, 32'hFFFF_FFF9, 1'b0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    chk("b2b_addr", 32'(imem_addr), 32'h3FFE);
    repeat (8) cyc(1'b1, 1'b0, 32'h0, 1'b0);

    // asynchronous reset mid-stream with a full buffer
    repeat (3) cyc(1'b0, 1'b0, 32'h0, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(id_valid), 32'd0);
    chk("arst_req", 32'(imem_req), 32'd0);
    repeat (2) @(posedge clk);
    boot_check("reboot");

    // random stress against the architectural PC order
    hs_before = hs;
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, $urandom, 1'b0);
    end
    repeat (6) cyc(1'b1, 1'b0, 32'h0, 1'b0);
    chk("stress_progress", 32'(hs - hs_before > 1000), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
